// File: rtl/ef_smsdac_msd_pkg.sv
// ef_smsdac_pkg: shared sizes, segment level codes and level decode for the MSD DAC
package ef_smsdac_pkg;
    localparam int NSEG  = 7;
    localparam int V_W   = 10;
    localparam int ACC_W = 4;
    typedef enum logic [1:0] {
        LVL_ZERO = 2'b00,
        LVL_POS  = 2'b01,
        LVL_NEG  = 2'b10,
        LVL_ILL  = 2'b11
    } lvl_code_e;
    // Illegal codes decode as level 0 so they contribute nothing downstream
    function automatic logic signed [1:0] lvl_decode(input logic [1:0] code);
        return (code == LVL_POS) ? 2'sb01 : (code == LVL_NEG) ? 2'sb11 : 2'sb00;
    endfunction
endpackage

// File: rtl/ef_smsdac_msd_seg.sv
// ef_smsdac_msd_seg: one segment's decode, illegal detect and shaping monitor (EF_SMSDAC_MSD_MON_EN)
module ef_smsdac_msd_seg
    import ef_smsdac_pkg::*;
#(
    parameter int BOUND = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              i_vld,
    input  logic [1:0]        i_y,
    output logic signed [1:0] o_lvl,
    output logic              o_ill,
    output logic              o_ovf
);
    assign o_lvl = lvl_decode(i_y);
    assign o_ill = i_y == LVL_ILL;
`ifdef EF_SMSDAC_MSD_MON_EN
    localparam logic signed [ACC_W-1:0] P_BND = ACC_W'(BOUND);
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W:0]   w_sum;
    logic                    w_over;
    logic                    r_pend;
    logic                    r_ovf;
    // Saturating integrator step; disagreeing top bits of the widened sum mean overflow
    always_comb begin
        w_sum  = (ACC_W+1)'(r_acc) + (ACC_W+1)'(o_lvl);
        w_acc  = (w_sum[ACC_W] != w_sum[ACC_W-1]) ? {w_sum[ACC_W], {(ACC_W-1){~w_sum[ACC_W]}}} : w_sum[ACC_W-1:0];
        w_over = (w_acc > P_BND) || (w_acc < -P_BND);
    end
    // Integrate at stage 1, publish the sticky violation one edge later alongside v_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_pend <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (clr) begin
            r_acc  <= '0;
            r_pend <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (i_vld) r_acc <= w_acc;
            r_pend <= i_vld & w_over;
            r_ovf  <= r_ovf | r_pend;
        end
    end
    assign o_ovf = r_ovf;
`else
    logic w_unused;
    assign w_unused = ^{clk, rst, clr, i_vld, BOUND != 0};
    assign o_ovf    = 1'b0;
`endif
endmodule

// File: rtl/ef_smsdac_msd.sv
// ef_smsdac_msd: 2-stage MSD segment reconstruction with illegal-code stats; monitor via EF_SMSDAC_MSD_MON_EN
module ef_smsdac_msd
    import ef_smsdac_pkg::*;
#(
    parameter int BOUND = 2,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [1:0]            y0,
    input  logic [1:0]            y1,
    input  logic [1:0]            y2,
    input  logic [1:0]            y3,
    input  logic [1:0]            y4,
    input  logic [1:0]            y5,
    input  logic [1:0]            y6,
    input  logic                  y_c,
    input  logic                  clr,
    output logic signed [V_W-1:0] v,
    output logic                  v_valid,
    output logic                  ill_flag,
    output logic [CNT_W-1:0]      ill_cnt,
    output logic [NSEG-1:0]       seg_ovf
);
    logic [1:0]            w_y   [NSEG];
    logic signed [1:0]     w_lvl [NSEG];
    logic signed [1:0]     r_lvl [NSEG];
    logic [NSEG-1:0]       w_ill;
    logic                  r_yc;
    logic                  r_vld1;
    logic                  r_vld2;
    logic                  r_flag;
    logic signed [V_W-1:0] r_v;
    logic signed [V_W-1:0] w_sum;
    logic [CNT_W-1:0]      r_cnt;
    logic [2:0]            w_nill;
    logic [CNT_W:0]        w_cnt;
    assign w_y = '{y0, y1, y2, y3, y4, y5, y6};
    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        ef_smsdac_msd_seg #(.BOUND(BOUND)) u_seg (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .i_vld (in_valid),
            .i_y   (w_y[k]),
            .o_lvl (w_lvl[k]),
            .o_ill (w_ill[k]),
            .o_ovf (seg_ovf[k])
        );
    end
    // Weighted sum of the registered levels, each sign-extended before shifting
    always_comb begin
        w_sum = {2'b00, r_yc, 7'b0};
        for (int k = 0; k < NSEG; k++) w_sum = w_sum + ({{(V_W-2){r_lvl[k][1]}}, r_lvl[k]} << k);
    end
    // Illegal segments in the incoming sample, added with one spare bit to catch saturation
    always_comb begin
        w_nill = '0;
        for (int k = 0; k < NSEG; k++) w_nill = w_nill + 3'(w_ill[k]);
        w_cnt = {1'b0, r_cnt} + (CNT_W+1)'(w_nill);
    end
    // Stage 1: capture decoded levels and carry; clr never touches pipeline data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld1 <= 1'b0;
            r_yc   <= 1'b0;
            r_lvl  <= '{default: '0};
        end else begin
            r_vld1 <= in_valid;
            if (in_valid) begin
                r_yc  <= y_c;
                r_lvl <= w_lvl;
            end
        end
    end
    // Illegal-code statistics; clr takes priority over a coincident sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else if (in_valid) begin
            r_cnt  <= w_cnt[CNT_W] ? '1 : w_cnt[CNT_W-1:0];
            r_flag <= r_flag | (|w_ill);
        end
    end
    // Stage 2: register v, holding it between valid samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld2 <= 1'b0;
            r_v    <= '0;
        end else begin
            r_vld2 <= r_vld1;
            if (r_vld1) r_v <= w_sum;
        end
    end
    assign v        = r_v;
    assign v_valid  = r_vld2;
    assign ill_flag = r_flag;
    assign ill_cnt  = r_cnt;
endmodule

// File: tb/tb_ef_smsdac_msd.sv
// tb_ef_smsdac_msd: directed table, corner sequences and random traffic against a behavioural model
module tb_ef_smsdac_msd;
    localparam int BOUND = 2;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef EF_SMSDAC_MSD_MON_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif
    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              y_c;
    logic              clr;
    logic [1:0]        y0, y1, y2, y3, y4, y5, y6;
    logic signed [9:0] v;
    logic              v_valid;
    logic              ill_flag;
    logic [CNT_W-1:0]  ill_cnt;
    logic [6:0]        seg_ovf;
    int n_chk = 0;
    int n_err = 0;
    typedef struct {
        bit vld;
        int v;
    } pe_t;
    typedef struct {
        logic [13:0] yv;
        bit          yc;
        int          exp_v;
        int          exp_nill;
    } vec_t;
    pe_t        q[$];
    vec_t       tbl[8];
    int         e_v;
    int         e_cnt;
    bit         e_vld;
    bit         e_flag;
    int         acc[7];
    bit         pend[7];
    logic [6:0] e_ovf;
    ef_smsdac_msd #(.BOUND(BOUND), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .y0       (y0),
        .y1       (y1),
        .y2       (y2),
        .y3       (y3),
        .y4       (y4),
        .y5       (y5),
        .y6       (y6),
        .y_c      (y_c),
        .clr      (clr),
        .v        (v),
        .v_valid  (v_valid),
        .ill_flag (ill_flag),
        .ill_cnt  (ill_cnt),
        .seg_ovf  (seg_ovf)
    );
    always #5 clk = ~clk;
    function automatic int lvl(input logic [1:0] c);
        return (c == 2'b01) ? 1 : (c == 2'b10) ? -1 : 0;
    endfunction
    function automatic int ref_v(input logic [13:0] yv, input bit yc);
        int s = yc ? 128 : 0;
        for (int k = 0; k < 7; k++) s += lvl(yv[2*k +: 2]) * (1 << k);
        return s;
    endfunction
    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic mdl_reset();
        q.delete();
        e_v = 0; e_vld = 1'b0; e_cnt = 0; e_flag = 1'b0; e_ovf = '0;
        for (int k = 0; k < 7; k++) begin acc[k] = 0; pend[k] = 1'b0; end
    endtask
    task automatic chk_all(input string tag);
        chk({tag, "_v"}, int'(v), e_v);
        chk({tag, "_v_valid"}, int'(v_valid), int'(e_vld));
        chk({tag, "_ill_cnt"}, int'(ill_cnt), e_cnt);
        chk({tag, "_ill_flag"}, int'(ill_flag), int'(e_flag));
        chk({tag, "_seg_ovf"}, int'(seg_ovf), int'(e_ovf));
    endtask
    // One clock: drive inputs, advance the model across the edge, compare just after it
    task automatic cyc(input bit iv, input logic [13:0] yv, input bit yc, input bit c);
        pe_t e;
        int n, a;
        {y6, y5, y4, y3, y2, y1, y0} = yv;
        in_valid = iv; y_c = yc; clr = c;
        @(posedge clk);
        e.vld = iv;
        e.v   = ref_v(yv, yc);
        q.push_back(e);
        e_vld = 1'b0;
        if (q.size() > 1) begin
            e = q.pop_front();
            e_vld = e.vld;
            if (e.vld) e_v = e.v;
        end
        for (int k = 0; k < 7; k++) e_ovf[k] = MON && !c && (e_ovf[k] || pend[k]);
        if (c) begin
            e_cnt = 0; e_flag = 1'b0;
            for (int k = 0; k < 7; k++) begin acc[k] = 0; pend[k] = 1'b0; end
        end else begin
            n = 0;
            for (int k = 0; k < 7; k++) begin
                if (yv[2*k +: 2] == 2'b11) n++;
                pend[k] = 1'b0;
                if (iv) begin
                    a = acc[k] + lvl(yv[2*k +: 2]);
                    acc[k] = (a > 7) ? 7 : (a < -8) ? -8 : a;
                    pend[k] = (acc[k] > BOUND) || (acc[k] < -BOUND);
                end
            end
            if (iv) begin
                e_cnt  = (e_cnt + n > CMAX) ? CMAX : e_cnt + n;
                e_flag = e_flag || (n > 0);
            end
        end
        #1;
        chk_all("cyc");
    endtask
    initial begin
        tbl[0] = '{14'h1555, 1'b1,  255, 0};
        tbl[1] = '{14'h2AAA, 1'b0, -127, 0};
        tbl[2] = '{14'h0000, 1'b1,  128, 0};
        tbl[3] = '{14'h00C0, 1'b0,    0, 1};
        tbl[4] = '{14'h0001, 1'b0,    1, 0};
        tbl[5] = '{14'h2000, 1'b1,   64, 0};
        tbl[6] = '{14'h3FFF, 1'b0,    0, 7};
        tbl[7] = '{14'h1002, 1'b0,   63, 0};
        rst = 1'b1; in_valid = 1'b0; clr = 1'b0; y_c = 1'b0;
        {y6, y5, y4, y3, y2, y1, y0} = '0;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_v", int'(v), 0);
        chk("reset_v_valid", int'(v_valid), 0);
        chk("reset_ill_flag", int'(ill_flag), 0);
        chk("reset_ill_cnt", int'(ill_cnt), 0);
        chk("reset_seg_ovf", int'(seg_ovf), 0);
        rst = 1'b0;
        foreach (tbl[i]) begin
            cyc(1'b0, '0, 1'b0, 1'b1);
            cyc(1'b1, tbl[i].yv, tbl[i].yc, 1'b0);
            chk("tbl_ill_cnt", int'(ill_cnt), tbl[i].exp_nill);
            chk("tbl_not_yet_valid", int'(v_valid), 0);
            cyc(1'b0, '0, 1'b0, 1'b0);
            chk("tbl_v", int'(v), tbl[i].exp_v);
            chk("tbl_v_valid", int'(v_valid), 1);
            cyc(1'b0, '0, 1'b0, 1'b0);
            chk("tbl_v_valid_drop", int'(v_valid), 0);
            chk("tbl_v_hold", int'(v), tbl[i].exp_v);
        end
        cyc(1'b0, '0, 1'b0, 1'b1);
        repeat (3) cyc(1'b1, 14'h00C0, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, '0, 1'b0, 1'b0);
        chk("ill3_cnt", int'(ill_cnt), 3);
        chk("ill3_flag", int'(ill_flag), 1);
        chk("ill3_v", int'(v), 0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("clr_cnt", int'(ill_cnt), 0);
        chk("clr_flag", int'(ill_flag), 0);
        repeat (3) cyc(1'b1, 14'h0001, 1'b0, 1'b0);
        chk("ovf_pending", int'(seg_ovf), 0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("ovf_after3", int'(seg_ovf), MON ? 1 : 0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_clr", int'(seg_ovf), 0);
        for (int i = 0; i < 100; i++) cyc(1'b1, (i % 2) ? 14'h0002 : 14'h0001, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, '0, 1'b0, 1'b0);
        chk("ovf_alternating", int'(seg_ovf), 0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        repeat (300) cyc(1'b1, 14'h3FFF, 1'($urandom_range(0, 1)), 1'b0);
        chk("sat_cnt", int'(ill_cnt), CMAX);
        chk("sat_flag", int'(ill_flag), 1);
        cyc(1'b1, 14'h1555, 1'b1, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        mdl_reset();
        chk_all("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            cyc(1'b0, '0, 1'b0, 1'b0);
            chk("rst_no_pulse", int'(v_valid), 0);
        end
        cyc(1'b1, 14'h00C0, 1'b0, 1'b0);
        chk("pre_clr_cnt", int'(ill_cnt), 1);
        cyc(1'b1, 14'h00C1, 1'b0, 1'b1);
        chk("clr_ill_cnt", int'(ill_cnt), 0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("clr_sample_v", int'(v), 1);
        chk("clr_sample_valid", int'(v_valid), 1);
        repeat (400) cyc($urandom_range(0, 3) != 0, 14'($urandom), 1'($urandom), $urandom_range(0, 15) == 0);
        repeat (2) cyc(1'b0, '0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
